// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..terminal and flags the last clock of each period.
module uart_bit_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] terminal,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = !clear && (cnt_q == terminal);

    // Restarts from zero on every period boundary, so it never runs past terminal.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO and sends each as a UART frame on tx.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned CNT_W = cnt_width(STOP_BITS * CLKS_PER_BIT);
    localparam int unsigned BIT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_TC  = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                tx_q, tx_d;
    logic                rd_en_q, rd_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                timer_clear;
    logic [CNT_W-1:0]    timer_tc;
    logic                tick;

    // Timer only runs in the line-driving states; stop uses the longer period.
    assign timer_clear = !(state_q inside {START, DATA, STOP});
    assign timer_tc    = (state_q == STOP) ? STOP_TC : BIT_TC;

    uart_bit_timer #(
        .CNT_W(CNT_W)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .terminal(timer_tc),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rd_en_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (tx_en && !fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            // FIFO data_out is valid here, one clock after the pop was sampled.
            LOAD: begin
                shift_d = fifo_data;
                bit_d   = '0;
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        tx_d    = IDLE_LEVEL;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: small FIFO model upstream, UART line monitor and byte scoreboard downstream.
module tb_fifo_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned FRAME = (2 + DW) * CPB;
    localparam int unsigned PERIOD_B2B = FRAME + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_en;
    logic [7:0]   fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         tx;
    logic         busy;
    logic         tx_done;

    // Upstream FIFO model (16 deep, registered data_out)
    logic         frst;
    logic         wr_en;
    logic [7:0]   wr_data;
    logic [7:0]   mem [16];
    logic [3:0]   rd_ptr, wr_ptr;
    logic [4:0]   fifo_cnt;
    logic         do_wr, do_rd;
    int           bad_pop = 0;

    assign fifo_empty = (fifo_cnt == 5'd0);
    assign do_wr      = wr_en && (fifo_cnt != 5'd16);
    assign do_rd      = fifo_rd_en && !fifo_empty;

    always_ff @(posedge clk) begin
        if (frst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_cnt  <= '0;
            fifo_dout <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 4'd1;
            end
            if (do_rd) begin
                fifo_dout <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 4'd1;
            end
            if (fifo_rd_en && fifo_empty) begin
                bad_pop <= bad_pop + 1;
            end
            fifo_cnt <= fifo_cnt + 5'(do_wr) - 5'(do_rd);
        end
    end

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW),
        .STOP_BITS   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo_data (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb [$];
    int          start_cyc [$];
    int          ncyc = 0;
    int          pops = 0;
    int          dones = 0;
    int          last_rd = 0, last_start = 0, last_done = 0;
    logic        tx_low_seen = 1'b0, busy_seen = 1'b0;
    logic        busy_last = 1'b0, busy_pre = 1'b0, busy_post = 1'b1, done_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line monitor: checks every clock of each frame against the scoreboard head.
    initial begin : monitor
        logic       active;
        int         cnt;
        logic       bad;
        logic [7:0] got, exp_b, front;
        logic       lvl;
        active = 1'b0;
        cnt = 0;
        bad = 1'b0;
        got = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (fifo_rd_en === 1'b1) begin pops++; last_rd = ncyc; end
            if (done_prev) busy_post = busy;
            if (tx_done === 1'b1) begin dones++; last_done = ncyc; busy_pre = busy_last; end
            done_prev = (tx_done === 1'b1);
            busy_last = busy;
            if (tx === 1'b0) tx_low_seen = 1'b1;
            if (busy === 1'b1) busy_seen = 1'b1;
            if (rst === 1'b1) begin
                active = 1'b0;
            end else begin
                if (!active && tx === 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                    bad = 1'b0;
                    got = '0;
                    start_cyc.push_back(ncyc);
                    last_start = ncyc;
                end
                if (active) begin
                    front = (sb.size() != 0) ? sb[0] : 8'h00;
                    if (sb.size() == 0) bad = 1'b1;
                    if (cnt < int'(CPB)) lvl = 1'b0;
                    else if (cnt < int'(CPB * (DW + 1))) lvl = front[(cnt - int'(CPB)) / int'(CPB)];
                    else lvl = 1'b1;
                    if (tx !== lvl) bad = 1'b1;
                    if (cnt >= int'(CPB) && cnt < int'(CPB * (DW + 1)) && (cnt % int'(CPB)) == int'(CPB / 2))
                        got[(cnt - int'(CPB)) / int'(CPB)] = tx;
                    if (cnt == int'(FRAME) - 1) begin
                        exp_b = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
                        checks++;
                        assert ({bad, got} === {1'b0, exp_b}) else begin
                            errors++;
                            $error("FAIL frame: observed %0h (line_err=%0b) expected %0h", got, bad, exp_b);
                        end
                        active = 1'b0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (dones < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(dones >= target), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int d0, p0, n;
        rst = 1'b1; frst = 1'b1; tx_en = 1'b0; wr_en = 1'b0; wr_data = '0;
        step(); step();
        frst = 1'b0;

        // Reset held with FIFO non-empty and tx_en high
        push(8'h11);
        tx_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        step();
        check("rst_no_pop", 32'(pops), 32'd0);
        check("rst_fifo_cnt", 32'(fifo_cnt), 32'd1);

        // Single byte
        sb.push_back(8'h11);
        rst = 1'b0;
        wait_done("single_done", 1, 200);
        step(); step();
        check("single_pops", 32'(pops), 32'd1);
        check("single_dones", 32'(dones), 32'd1);
        check("single_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("single_latency", 32'(last_start - last_rd), 32'd2);
        check("single_length", 32'(last_done - last_start), 32'(FRAME));
        check("single_sb_empty", 32'(sb.size()), 32'd0);

        // Burst of 12 bytes
        tx_en = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            push(8'(8'h11 * i));
            sb.push_back(8'(8'h11 * i));
        end
        start_cyc.delete();
        d0 = dones; p0 = pops;
        tx_en = 1'b1;
        wait_done("burst_done", d0 + 12, 12 * int'(PERIOD_B2B) + 100);
        step(); step(); step();
        check("burst_frames", 32'(start_cyc.size()), 32'd12);
        for (int i = 1; i < start_cyc.size(); i++)
            check("burst_period", 32'(start_cyc[i] - start_cyc[i-1]), 32'(PERIOD_B2B));
        check("burst_empty", 32'(fifo_empty), 32'd1);
        check("burst_pops", 32'(pops - p0), 32'd12);
        check("burst_busy_pre", 32'(busy_pre), 32'd1);
        check("burst_busy_post", 32'(busy_post), 32'd0);
        check("burst_sb_empty", 32'(sb.size()), 32'd0);

        // tx_en gating and mid-frame drop
        tx_en = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
        tx_low_seen = 1'b0;
        p0 = pops; d0 = dones;
        repeat (60) step();
        check("gate_no_pop", 32'(pops - p0), 32'd0);
        check("gate_tx_idle", 32'(tx_low_seen), 32'd0);
        check("gate_fifo_cnt", 32'(fifo_cnt), 32'd3);
        sb.push_back(8'h11);
        tx_en = 1'b1;
        repeat (12) step();
        tx_en = 1'b0;
        wait_done("gate_done", d0 + 1, 200);
        repeat (100) step();
        check("gate_dones", 32'(dones - d0), 32'd1);
        check("gate_fifo_cnt_end", 32'(fifo_cnt), 32'd2);
        check("gate_pops", 32'(pops - p0), 32'd1);

        // Reset in the middle of the data bits of 8'hA5
        frst = 1'b1; step(); frst = 1'b0;
        check("flush_fifo_cnt", 32'(fifo_cnt), 32'd0);
        push(8'hA5); push(8'h5A);
        sb.push_back(8'h5A);
        d0 = dones; p0 = pops;
        tx_low_seen = 1'b0;
        tx_en = 1'b1;
        n = 0;
        while (!tx_low_seen && n < 50) begin step(); n++; end
        check("rst_mid_started", 32'(tx_low_seen), 32'd1);
        repeat (10) step();
        check("rst_mid_in_frame", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_no_done", 32'(dones - d0), 32'd0);
        wait_done("rst_mid_next_done", d0 + 1, 200);
        repeat (5) step();
        check("rst_mid_dones", 32'(dones - d0), 32'd1);
        check("rst_mid_pops", 32'(pops - p0), 32'd2);
        check("rst_mid_sb_empty", 32'(sb.size()), 32'd0);

        // Empty FIFO with tx_en high
        tx_low_seen = 1'b0; busy_seen = 1'b0;
        p0 = pops;
        repeat (100) step();
        check("empty_no_pop", 32'(pops - p0), 32'd0);
        check("empty_tx_idle", 32'(tx_low_seen), 32'd0);
        check("empty_not_busy", 32'(busy_seen), 32'd0);
        check("empty_tx", 32'(tx), 32'd1);
        check("no_pop_when_empty", 32'(bad_pop), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
